// File: rtl/periph_bus_pkg.sv
`default_nettype none
// ============================================================================
// periph_bus_pkg : shared state type and bus constants for periph_bus_master
// Revision: 1.0
// ============================================================================
package periph_bus_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 4;

    localparam logic [ADDR_W-1:0] STATUS_ADDR = 3'h6;
    localparam logic [DATA_W-1:0] IRQ_CLEAR   = 8'h80;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RESP    = 3'd2,
        POLL_RD = 3'd3,
        POLL_WR = 3'd4
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/periph_bus_master_wait_counter.sv
`default_nettype none
// ============================================================================
// bus_wait_counter : loadable down-counter that stops at zero, done at zero
// Revision: 1.0
// ============================================================================
module bus_wait_counter
    import periph_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              done
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WAIT_W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/periph_bus_master.sv
`default_nettype none
// ============================================================================
// periph_bus_master : request/response to chip-select peripheral bus bridge
// Optional IRQ_AUTOPOLL_EN: services irq by reading/clearing STATUS_ADDR. Revision: 1.0
// ============================================================================
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rwb,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cs,
    output logic              rwb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data,
    input  logic              irq,
    output logic              irq_event,
    output logic [DATA_W-1:0] irq_status
);

    localparam logic [WAIT_W-1:0] c_wait_load = WAIT_W'(WAIT_CYCLES);

    bus_state_t        r_state;
    logic              r_cs;
    logic              r_rwb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_odata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic w_poll_start;
    logic w_accept;
    logic w_load;
    logic w_dec;
    logic w_done;

`ifdef IRQ_AUTOPOLL_EN
    assign w_poll_start = (r_state == IDLE) && irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq;
    assign w_poll_start = 1'b0;
`endif

    assign req_ready = (r_state == IDLE) && !w_poll_start;
    assign w_accept  = req_valid && req_ready;

    // POLL_WR spends its first cycle with cs low, so the counter only runs once cs is up
    always_comb begin
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE:    w_load = w_poll_start || w_accept;
            ACCESS:  w_dec  = !w_done;
            POLL_RD: begin
                w_dec  = !w_done;
                w_load = w_done && i_data[7];
            end
            POLL_WR: w_dec  = r_cs && !w_done;
            default: w_load = 1'b0;
        endcase
    end

    bus_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (c_wait_load),
        .dec        (w_dec),
        .done       (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cs        <= 1'b0;
            r_rwb       <= 1'b1;
            r_addr      <= '0;
            r_odata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_poll_start) begin
                        r_state <= POLL_RD;
                        r_cs    <= 1'b1;
                        r_rwb   <= 1'b1;
                        r_addr  <= STATUS_ADDR;
                        r_odata <= '0;
                    end else if (w_accept) begin
                        r_state <= ACCESS;
                        r_cs    <= 1'b1;
                        r_rwb   <= req_rwb;
                        r_addr  <= req_addr;
                        r_odata <= req_rwb ? '0 : req_wdata;
                    end
                end
                ACCESS: begin
                    if (w_done) begin
                        r_state     <= RESP;
                        r_cs        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_rwb ? i_data : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
`ifdef IRQ_AUTOPOLL_EN
                POLL_RD: begin
                    if (w_done) begin
                        r_cs <= 1'b0;
                        if (i_data[7]) begin
                            r_state <= POLL_WR;
                            r_rwb   <= 1'b0;
                            r_odata <= IRQ_CLEAR;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                POLL_WR: begin
                    if (!r_cs) begin
                        r_cs <= 1'b1;
                    end else if (w_done) begin
                        r_cs    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IRQ_AUTOPOLL_EN
    logic              r_irq_event;
    logic [DATA_W-1:0] r_irq_status;
    logic [DATA_W-1:0] r_status_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_event     <= 1'b0;
            r_irq_status    <= '0;
            r_status_sample <= '0;
        end else begin
            r_irq_event <= 1'b0;
            if ((r_state == POLL_RD) && w_done) begin
                r_status_sample <= i_data;
            end
            if ((r_state == POLL_WR) && r_cs && w_done) begin
                r_irq_event  <= 1'b1;
                r_irq_status <= r_status_sample;
            end
        end
    end

    assign irq_event  = r_irq_event;
    assign irq_status = r_irq_status;
`else
    assign irq_event  = 1'b0;
    assign irq_status = '0;
`endif

    assign cs        = r_cs;
    assign rwb       = r_rwb;
    assign addr      = r_addr;
    assign o_data    = r_odata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_master.sv
`default_nettype none
// ============================================================================
// tb_periph_bus_master : directed + randomized checks against a register-file peripheral model
// Revision: 1.0
// ============================================================================
module tb_periph_bus_master;

    localparam int WC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_rwb, rsp_ready, irq;
    logic [2:0] req_addr;
    logic [7:0] req_wdata, i_data;
    wire        req_ready, rsp_valid, cs, rwb, irq_event;
    wire  [2:0] addr;
    wire  [7:0] rsp_rdata, o_data, irq_status;

    logic       req_valid_z, rsp_ready_z;
    logic [7:0] i_data_z;
    wire        req_ready_z, rsp_valid_z, cs_z, rwb_z, irq_event_z;
    wire  [2:0] addr_z;
    wire  [7:0] rsp_rdata_z, o_data_z, irq_status_z;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] mem [8];

    always #5 clk = ~clk;

    periph_bus_master #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rwb(req_rwb), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .cs(cs), .rwb(rwb), .addr(addr), .o_data(o_data), .i_data(i_data),
        .irq(irq), .irq_event(irq_event), .irq_status(irq_status)
    );

    periph_bus_master #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
        .req_rwb(1'b1), .req_addr(3'd2), .req_wdata(8'h00),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .cs(cs_z), .rwb(rwb_z), .addr(addr_z), .o_data(o_data_z), .i_data(i_data_z),
        .irq(1'b0), .irq_event(irq_event_z), .irq_status(irq_status_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Peripheral side: cs must be up (within max_wait cycles) for WC+1 cycles; only the
    // last cycle carries the real read byte, the others carry junk.
    task automatic access_phase(input int max_wait, input bit rd, input logic [2:0] a,
                                input logic [7:0] wd, input logic [7:0] last_byte);
        int w = 0;
        while (cs !== 1'b1 && w < max_wait) begin
            tick();
            w++;
        end
        for (int k = 0; k <= WC; k++) begin
            check("cs_high", cs, 1);
            check("rwb", rwb, rd);
            check("addr", addr, a);
            check("o_data", o_data, rd ? 8'h00 : wd);
            check("req_ready_busy", req_ready, 0);
            i_data = (k == WC) ? last_byte : 8'($urandom);
            tick();
        end
        i_data = 8'($urandom);
        check("cs_low_after", cs, 0);
    endtask

    task automatic finish_rsp(input logic [7:0] exp_rd, input int stall);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, exp_rd);
            check("bp_req_ready", req_ready, 0);
            check("bp_cs", cs, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
    endtask

    task automatic txn(input bit rd, input logic [2:0] a, input logic [7:0] wd, input int stall);
        logic [7:0] exp_rd;
        logic [7:0] last_byte;
        exp_rd    = rd ? mem[a] : 8'h00;
        last_byte = rd ? mem[a] : 8'($urandom);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_rwb   = rd;
        req_addr  = a;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_rwb   = 1'($urandom);
        req_addr  = 3'($urandom);
        req_wdata = 8'($urandom);
        access_phase(0, rd, a, wd, last_byte);
        finish_rsp(exp_rd, stall);
        if (!rd) mem[a] = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        reset = 1'b1; req_valid = 1'b0; req_rwb = 1'b1; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; irq = 1'b0; i_data = '0;
        req_valid_z = 1'b0; rsp_ready_z = 1'b0; i_data_z = '0;
        repeat (3) tick();

        check("rst_cs", cs, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_irq_event", irq_event, 0);
        check("rst_rwb", rwb, 1);
        check("rst_addr", addr, 0);
        check("rst_o_data", o_data, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_irq_status", irq_status, 0);
        reset = 1'b0;
        check("rst_req_ready", req_ready, 1);
        tick();

        // Directed read, write, and backpressure
        mem[0] = 8'h5A;
        txn(1'b1, 3'd0, 8'h00, 0);
        txn(1'b0, 3'd5, 8'h03, 0);
        txn(1'b1, 3'd5, 8'h00, 4);

        // Reset during the first cs cycle aborts without response or retry
        req_valid = 1'b1; req_rwb = 1'b1; req_addr = 3'd3;
        tick();
        req_valid = 1'b0;
        check("abort_cs_started", cs, 1);
        reset = 1'b1;
        tick();
        check("abort_cs", cs, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_addr", addr, 0);
        reset = 1'b0;
        tick();
        check("abort_req_ready", req_ready, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("abort_no_retry_cs", cs, 0);
            check("abort_no_rsp", rsp_valid, 0);
        end

`ifdef IRQ_AUTOPOLL_EN
        // Poll takes priority over a simultaneous request, then the request is served
        req_valid = 1'b1; req_rwb = 1'b1; req_addr = 3'd0; irq = 1'b1;
        check("poll_req_ready", req_ready, 0);
        tick();
        access_phase(0, 1'b1, 3'h6, 8'h00, 8'h80);
        irq = 1'b0;
        access_phase(4, 1'b0, 3'h6, 8'h80, 8'($urandom));
        check("poll_irq_event", irq_event, 1);
        check("poll_irq_status", irq_status, 8'h80);
        check("poll_no_rsp", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        check("poll_event_pulse", irq_event, 0);
        access_phase(0, 1'b1, 3'd0, 8'h00, mem[0]);
        finish_rsp(mem[0], 0);
`else
        irq = 1'b1;
        check("noirq_req_ready", req_ready, 1);
        txn(1'b1, 3'd6, 8'h00, 0);
        check("noirq_event", irq_event, 0);
        check("noirq_status", irq_status, 0);
        irq = 1'b0;
`endif

        // Randomized traffic against the register-file model
        for (int t = 0; t < 24; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) tick();
            txn(1'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 2));
        end

        // Zero wait cycles: single-cycle cs, response two cycles after acceptance
        req_valid_z = 1'b1;
        tick();
        req_valid_z = 1'b0;
        check("w0_cs_high", cs_z, 1);
        check("w0_addr", addr_z, 3'd2);
        i_data_z = 8'h3C;
        tick();
        i_data_z = 8'h00;
        check("w0_cs_low", cs_z, 0);
        check("w0_rsp_valid", rsp_valid_z, 1);
        check("w0_rsp_rdata", rsp_rdata_z, 8'h3C);
        rsp_ready_z = 1'b1;
        tick();
        rsp_ready_z = 1'b0;
        check("w0_req_ready", req_ready_z, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
